// File: rtl/inst_mem_pkg.sv
// Shared constants and helpers for the pipelined instruction memory.
package inst_mem_pkg;

  // Legal range of the read-pipeline latency
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  // Word returned on faulted fetches (sliced to DATA_WIDTH by users)
  localparam logic [63:0] NOP_WORD = 64'h0;

  // Number of bits needed to index DEPTH words (log2 of a power of two)
  function automatic int idx_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < depth) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: one synchronous write port, one synchronous read port.
// Contents are deliberately not reset; the read register is qualified downstream.
module inst_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write and registered read kept in one block so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_mem_pipelined.sv
// Pipelined instruction memory: request/response fetch port with a LATENCY-deep
// read pipeline, loader write port, fault flags and an in-flight counter.
module inst_mem_pipelined
  import inst_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_instr,
  output logic                  resp_misaligned,
  output logic                  resp_oob,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [2:0]            inflight
);

  localparam int IDX_W = idx_width(DEPTH);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("inst_mem_pipelined: LATENCY out of range");
  end

  // Per-stage control/flag bits travelling alongside the read data
  typedef struct packed {
    logic vld;
    logic mis;
    logic oob;
  } stage_t;

  stage_t [LATENCY-1:0]  pipe_q, pipe_d;
  logic [2:0]            inflight_q, inflight_d;
  logic                  accept;
  logic                  req_mis, req_oob, load_ok;
  logic [DATA_WIDTH-1:0] rd_data, data_out;
  stage_t                out_s;

  // Loads win over fetches; the fetch must be held until load_en drops
  assign req_ready = rst_n && !load_en;
  assign accept    = req_valid && req_ready;

  // Misalignment takes priority, so oob is only raised for aligned addresses
  assign req_mis = |req_addr[1:0];
  assign req_oob = !req_mis && (|(req_addr >> (IDX_W + 2)));
  assign load_ok = load_en && !(|load_addr[1:0]) && !(|(load_addr >> (IDX_W + 2)));

  inst_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (load_ok),
    .wr_addr (load_addr[IDX_W+1:2]),
    .wr_data (load_data),
    .rd_en   (accept),
    .rd_addr (req_addr[IDX_W+1:2]),
    .rd_data (rd_data)
  );

  // Next state of the flag pipeline: stage 0 captures the accepted request
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = '{vld: accept, mis: accept && req_mis, oob: accept && req_oob};
    for (int k = 1; k < LATENCY; k++) pipe_d[k] = pipe_q[k-1];
  end

  // Flag pipeline; reset discards every in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  // Stage 0 data is the array read register; later stages are plain flops
  if (LATENCY == 1) begin : g_lat1
    assign data_out = rd_data;
  end else begin : g_latn
    logic [LATENCY-1:1][DATA_WIDTH-1:0] data_q, data_d;

    // Shift read data toward the output every cycle
    always_comb begin
      data_d    = data_q;
      data_d[1] = rd_data;
      for (int k = 2; k < LATENCY; k++) data_d[k] = data_q[k-1];
    end

    // Data pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
    end

    assign data_out = data_q[LATENCY-1];
  end

  assign out_s           = pipe_q[LATENCY-1];
  assign resp_valid      = out_s.vld;
  assign resp_misaligned = out_s.mis;
  assign resp_oob        = out_s.oob;
  // Only a clean valid fetch exposes array data; the read register is unreset
  assign resp_instr      = (out_s.vld && !out_s.mis && !out_s.oob) ?
                           data_out : NOP_WORD[DATA_WIDTH-1:0];

  // In-flight count: +1 on accept, -1 as a response leaves
  always_comb begin
    inflight_d = inflight_q;
    case ({accept, resp_valid})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // In-flight counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= 3'd0;
    else        inflight_q <= inflight_d;
  end

  assign inflight = inflight_q;

endmodule

// File: tb/tb_inst_mem_pipelined.sv
// Bench: three instances (LATENCY 1, 2, 4) share one stimulus stream and are
// checked against a transaction-level model of memory contents and responses.
module tb_inst_mem_pipelined;

  localparam int NDUT  = 3;
  localparam int DEPTH = 256;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  logic [NDUT-1:0] rr, rv, rmis, roob;
  logic [31:0]     ri   [NDUT];
  logic [2:0]      infl [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    inst_mem_pipelined #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .DEPTH      (DEPTH),
      .LATENCY    (lat_of(g))
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (rr[g]),
      .req_addr        (req_addr),
      .resp_valid      (rv[g]),
      .resp_instr      (ri[g]),
      .resp_misaligned (rmis[g]),
      .resp_oob        (roob[g]),
      .load_en         (load_en),
      .load_addr       (load_addr),
      .load_data       (load_data),
      .inflight        (infl[g])
    );
  end

  // Reference model: accepted requests in order, with accept edge and result
  typedef struct {
    int          acc;
    logic [31:0] data;
    logic        mis;
    logic        oob;
  } exp_t;

  exp_t        q[$];
  int          head [NDUT];
  int          ecnt;
  int          checks;
  int          errors;
  logic [31:0] mem_m [DEPTH];
  int          loaded[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every instance against the model, sampled at the falling edge
  task automatic check_outputs();
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d ready e%0d", d, ecnt), {31'b0, rr[d]}, {31'b0, rst_n && !load_en});
      chk($sformatf("d%0d inflight e%0d", d, ecnt), {29'b0, infl[d]}, q.size() - head[d]);
      if (head[d] < q.size() && q[head[d]].acc + lat_of(d) - 1 == ecnt) begin
        chk($sformatf("d%0d valid e%0d", d, ecnt), {31'b0, rv[d]}, 32'd1);
        chk($sformatf("d%0d instr e%0d", d, ecnt), ri[d], q[head[d]].data);
        chk($sformatf("d%0d mis e%0d", d, ecnt), {31'b0, rmis[d]}, {31'b0, q[head[d]].mis});
        chk($sformatf("d%0d oob e%0d", d, ecnt), {31'b0, roob[d]}, {31'b0, q[head[d]].oob});
        head[d]++;
      end else begin
        chk($sformatf("d%0d idle e%0d", d, ecnt), {31'b0, rv[d]}, 32'd0);
      end
    end
  endtask

  // One clock: model the edge from the current inputs, then check
  task automatic step();
    exp_t e;
    int   idx;
    @(posedge clk);
    ecnt++;
    if (rst_n && req_valid && !load_en) begin
      e.acc  = ecnt;
      e.mis  = (req_addr[1:0] != 2'b00);
      e.oob  = !e.mis && ((req_addr >> 2) >= DEPTH);
      idx    = int'(req_addr[9:2]);
      e.data = (e.mis || e.oob) ? 32'h0 : mem_m[idx];
      q.push_back(e);
    end
    if (rst_n && load_en && load_addr[1:0] == 2'b00 && (load_addr >> 2) < DEPTH) begin
      idx        = int'(load_addr[9:2]);
      mem_m[idx] = load_data;
      loaded.push_back(idx);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_req(input logic [31:0] a);
    req_valid = 1'b1; req_addr = a; load_en = 1'b0;
    step();
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] dat);
    req_valid = 1'b0; load_en = 1'b1; load_addr = a; load_data = dat;
    step();
    load_en = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0; load_en = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset with immediate output checks; model drops in-flight work
  task automatic async_reset();
    rst_n = 1'b0; req_valid = 1'b0; load_en = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d rst valid", d), {31'b0, rv[d]}, 32'd0);
      chk($sformatf("d%0d rst instr", d), ri[d], 32'd0);
      chk($sformatf("d%0d rst flags", d), {30'b0, rmis[d], roob[d]}, 32'd0);
      chk($sformatf("d%0d rst inflight", d), {29'b0, infl[d]}, 32'd0);
      chk($sformatf("d%0d rst ready", d), {31'b0, rr[d]}, 32'd0);
      head[d] = q.size();
    end
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_good_addr();
    return {22'b0, loaded[$urandom_range(0, loaded.size() - 1)][7:0], 2'b00};
  endfunction

  initial begin
    int          r;
    logic [31:0] a;
    checks = 0; errors = 0; ecnt = 0;
    for (int d = 0; d < NDUT; d++) head[d] = 0;

    // Power-on reset
    step();
    step();
    async_reset();

    // Program image and basic back-to-back fetch
    do_load(32'h0, 32'h2008_0005);
    do_load(32'h4, 32'h2009_0007);
    do_load(32'h8, 32'h1234_5678);
    do_req(32'h0);
    do_req(32'h4);
    idle(5);

    // Fault flags
    do_req(32'h6);
    do_req(32'h400);
    do_req(32'hFFFF_FFFF);
    idle(5);

    // Request held while loads own the port for three cycles
    req_valid = 1'b1; req_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      load_en = 1'b1; load_addr = 32'h10 + 32'(4 * i); load_data = 32'hA000_0000 + 32'(i);
      step();
      for (int d = 0; d < NDUT; d++) chk($sformatf("d%0d held ready %0d", d, i), {31'b0, rr[d]}, 32'd0);
    end
    load_en = 1'b0;
    step();
    idle(5);

    // Dropped loads: misaligned and out of range must not disturb the array
    do_load(32'h9, 32'hDEAD_0001);
    do_load(32'h408, 32'hDEAD_0002);
    do_req(32'h8);
    idle(5);

    // In-flight read keeps the old word; a later fetch sees the new one
    do_req(32'h0);
    do_load(32'h0, 32'hFFFF_FFFF);
    do_req(32'h0);
    idle(5);

    // Three requests in flight, then reset: none of them may respond
    do_req(32'h4);
    do_req(32'h8);
    do_req(32'h10);
    async_reset();
    idle(6);

    // Fill more words, then 16 back-to-back fetches
    for (int i = 0; i < 24; i++) do_load({22'b0, 8'($urandom), 2'b00}, $urandom);
    for (int i = 0; i < 16; i++) do_req(rand_good_addr());
    idle(5);

    // Random mix of loads (some dropped), fetches, faults and bubbles
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        load_en   = 1'b1;
        load_data = $urandom;
        case ($urandom_range(0, 3))
          0:       load_addr = {22'b0, 8'($urandom), 2'b01};
          1:       load_addr = {$urandom_range(256, 1000), 2'b00};
          default: load_addr = {22'b0, 8'($urandom), 2'b00};
        endcase
        req_valid = ($urandom_range(0, 1) == 1);
        req_addr  = rand_good_addr();
      end else begin
        load_en = 1'b0;
        case (r)
          2:       a = {$urandom_range(0, 1023), 2'($urandom_range(1, 3))};
          3:       a = {$urandom_range(256, 30'h3FFF_FFFF), 2'b00};
          default: a = rand_good_addr();
        endcase
        req_addr  = a;
        req_valid = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_pipelined.md
# inst_mem_pipelined

Parametrised instruction memory with a request/response read port, a configurable read-pipeline latency and a loader write port for filling program images at run time. Sits between the fetch stage and the instruction storage, replacing the fixed single-cycle instruction memory when the core moves to a pipelined fetch. Reports misaligned and out-of-range fetches as flags on the response rather than returning garbage.

## Interface
- DATA_WIDTH, 32: instruction word width in bits.
- ADDR_WIDTH, 32: byte-address width.
- DEPTH, 256: number of instruction words stored (power of two, ≥ 4).
- LATENCY, 2: cycles from request accept to response valid (legal range 1..4).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  block can accept a request this cycle.
- req_addr  in  ADDR_WIDTH  byte address of the requested instruction.
- resp_valid  out  1  response word valid this cycle (one-cycle pulse per request).
- resp_instr  out  DATA_WIDTH  fetched instruction, or NOP (all zeros) on fault.
- resp_misaligned  out  1  request address had req_addr[1:0] ≠ 0.
- resp_oob  out  1  request word index ≥ DEPTH.
- load_en  in  1  write one word into the array this cycle.
- load_addr  in  ADDR_WIDTH  byte address of the word to write.
- load_data  in  DATA_WIDTH  word to write.
- inflight  out  3  number of accepted requests not yet responded (0..LATENCY).

## Operation
- Request accepted on a rising edge where req_valid && req_ready.
- req_ready = rst_n && !load_en; loads have priority, a request presented with load_en high is not accepted and must be held.
- Word index = req_addr >> 2; array read at the accept edge into stage 0 of a LATENCY-deep valid/data/flag shift pipeline; pipeline advances every cycle (no response backpressure).
- Fault priority: misaligned checked first; if misaligned, resp_oob = 0 and resp_instr = 0. If aligned and index ≥ DEPTH, resp_oob = 1, resp_instr = 0. Both flags are 0 on a good fetch.
- Load: on a rising edge with load_en, if load_addr aligned and in range, array[load_addr >> 2] <= load_data; otherwise the write is silently dropped.
- Read data is captured at accept; a later load to the same word does not change an in-flight response.
- inflight increments on accept, decrements on resp_valid, unchanged when both occur in the same cycle.
- Array contents are not reset; undefined until loaded.

## Timing
- Reset (asynchronous, immediate): resp_valid = 0, resp_instr = 0, resp_misaligned = 0, resp_oob = 0, inflight = 0, all pipeline valid bits cleared; req_ready = 0 while rst_n low.
- Reset mid-operation discards all in-flight requests; no response is ever produced for them.
- Request accepted at edge N → resp_valid high for the cycle after edge N+LATENCY−1 (i.e. LATENCY = 1 gives response in the cycle directly following the accept edge).
- Throughput: one request per cycle sustained when load_en low; back-to-back requests produce back-to-back responses in order.
- Load at edge N followed by a request accepted at edge N+1 to the same word returns the new data.
- All outputs registered; no combinational path from req_* or load_* to resp_*. req_ready depends combinationally on load_en only.

## Structure
- Shared package inst_mem_pkg: NOP word constant, LATENCY_MIN/LATENCY_MAX, word-index helper width function (log2 DEPTH).
- Sub-module inst_mem_array: DEPTH × DATA_WIDTH storage, one synchronous write port, one synchronous read port, no reset. Top level holds accept logic, fault decode, latency pipeline and inflight counter.

## Test plan
- Load 0x20080005 to 0x0, 0x20090007 to 0x4; LATENCY=2; requests 0x0, 0x4 on consecutive cycles → resp_valid on two consecutive cycles, data 0x20080005 then 0x20090007, flags 0, inflight peaks at 2.
- Request 0x6 → resp_instr 0, resp_misaligned 1, resp_oob 0; request 0x400 with DEPTH=256 → resp_instr 0, resp_oob 1.
- Request 0x8 held while load_en high for 3 cycles → req_ready 0 for those 3 cycles, accept on the first cycle load_en low, response LATENCY cycles later.
- Request 0x0 accepted, load 0xFFFFFFFF to 0x0 next cycle → in-flight response returns old word; a following request returns 0xFFFFFFFF.
- Three requests in flight, rst_n pulsed low → resp_valid 0 immediately, inflight 0, no responses after release.
- Sweep LATENCY 1 and 4 → accept-to-response distance exactly LATENCY cycles, sustained one-per-cycle throughput over 16 requests.
